// File: rtl/harvest_vote_filter.sv
// harvest_vote_filter
// Sliding-window majority vote with hysteresis on the classifier result
// stream, driving a latched harvest alarm (with ack) and a saturating count
// of HARVEST entries.
// Optional build macro: STREAK_EN adds a saturating consecutive-ready streak
// counter. When it is undefined, streak is tied to zero.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_FILL    | fewer than WIN results collected since reset/clear
// S_GROWING | window full, vote not (or no longer) in harvest range
// S_HARVEST | vote reached ON_THR, held until ones drop to OFF_THR

module harvest_vote_filter #(
  parameter int WIN     = 8,
  parameter int ON_THR  = 6,
  parameter int OFF_THR = 2,
  parameter int EVT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             result_valid,
  input  logic             result_class,
  input  logic             clear,
  input  logic             alarm_ack,
  output logic [4:0]       ones_count,
  output logic             window_full,
  output logic             harvest_state,
  output logic             alarm,
  output logic [EVT_W-1:0] event_count,
  output logic [3:0]       streak
);

  localparam logic [4:0] WIN_L     = 5'(WIN);
  localparam logic [4:0] ON_THR_L  = 5'(ON_THR);
  localparam logic [4:0] OFF_THR_L = 5'(OFF_THR);

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_GROWING = 2'd1,
    S_HARVEST = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             edge_q;
  logic [WIN-1:0]   window_q;
  logic [4:0]       fill_left_q;
  logic [4:0]       fill_left_d;
  logic [4:0]       ones_q;
  logic [4:0]       ones_d;
  logic             full_q;
  logic             full_d;
  logic             oldest;
  logic             accept;
  logic             enter_harvest;
  logic             alarm_q;
  logic [EVT_W-1:0] evt_q;

  // Fill tracking is a down-counter of results still needed; the window is
  // full at terminal count zero, after which it holds.
  assign accept      = ena & result_valid & ~edge_q & ~clear;
  assign full_q      = (fill_left_q == 5'd0);
  assign oldest      = window_q[WIN-1];
  assign fill_left_d = full_q ? 5'd0 : (fill_left_q - 5'd1);
  assign full_d      = (fill_left_d == 5'd0);
  // The oldest bit only leaves the count once the window is full; before
  // that it is a reset zero, never a real result.
  assign ones_d      = ones_q + {4'd0, result_class} - {4'd0, full_q & oldest};

  // Rising-edge detect on result_valid so a held level is accepted once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= 1'b0;
    end else if (ena) begin
      edge_q <= result_valid;
    end
  end

  // Window shift register, fill down-counter and running ones count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q    <= '0;
      fill_left_q <= WIN_L;
      ones_q      <= 5'd0;
    end else if (ena) begin
      if (clear) begin
        window_q    <= '0;
        fill_left_q <= WIN_L;
        ones_q      <= 5'd0;
      end else if (accept) begin
        window_q    <= {window_q[WIN-2:0], result_class};
        fill_left_q <= fill_left_d;
        ones_q      <= ones_d;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // FSM next state: only an accepted result (or clear) can move the vote.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_FILL;
    end else if (accept) begin
      case (state_q)
        S_FILL: begin
          if (full_d) begin
            state_d = (ones_d >= ON_THR_L) ? S_HARVEST : S_GROWING;
          end
        end
        S_GROWING: begin
          if (ones_d >= ON_THR_L) state_d = S_HARVEST;
        end
        S_HARVEST: begin
          if (ones_d <= OFF_THR_L) state_d = S_GROWING;
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // FSM outputs: state flag and the one-cycle HARVEST entry strobe.
  always_comb begin
    harvest_state = (state_q == S_HARVEST);
    enter_harvest = accept && (state_q != S_HARVEST) && (state_d == S_HARVEST);
  end

  // Latched alarm: clear beats set, set beats ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        alarm_q <= 1'b0;
      end else if (enter_harvest) begin
        alarm_q <= 1'b1;
      end else if (alarm_ack) begin
        alarm_q <= 1'b0;
      end
    end
  end

  // Saturating HARVEST entry counter; survives clear, only reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else if (ena && enter_harvest && (evt_q != '1)) begin
      evt_q <= evt_q + 1'b1;
    end
  end

`ifdef STREAK_EN
  logic [3:0] streak_q;

  // Consecutive accepted-ready streak, saturating at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= 4'd0;
    end else if (ena) begin
      if (clear) begin
        streak_q <= 4'd0;
      end else if (accept) begin
        if (!result_class) begin
          streak_q <= 4'd0;
        end else if (streak_q != 4'hF) begin
          streak_q <= streak_q + 4'd1;
        end
      end
    end
  end

  assign streak = streak_q;
`else
  assign streak = 4'd0;
`endif

  assign ones_count  = ones_q;
  assign window_full = full_q;
  assign alarm       = alarm_q;
  assign event_count = evt_q;

endmodule
